// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared types and constants for the data-memory responder
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// dmem_lane_align : byte-lane steering for stores and extension for loads
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = '0;
        rdata_ext   = '0;
        shifted     = rdata >> {lane, 3'b000};
        // Store data is replicated across lanes; the byte-enable picks the target lanes.
        case (size)
            MEM_BYTE: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                byte_en     = 4'b0011 << lane;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            MEM_WORD: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = shifted;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : latency-configurable data RAM behind a valid/ready req/rsp
//                  pair. Optional macro DMEM_MISALIGN_TRAP_EN faults misaligned
//                  half/word accesses instead of force-aligning them.
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic              iReqWrite,
    input  logic [1:0]        iReqSize,
    input  logic              iReqUnsigned,
    input  logic [ADDR_W-1:0] iReqAddr,
    input  logic [31:0]       iReqWData,
    output logic              oRspValid,
    input  logic              iRspReady,
    output logic [31:0]       oRspRData,
    output logic              oRspErr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_e        state;
    dmem_state_e        state_next;
    logic [CNT_W-1:0]   cnt;

    logic               req_write;
    logic               req_unsigned;
    mem_size_e          req_size;
    logic [IDX_W+1:0]   req_addr;
    logic [31:0]        req_wdata;

    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               commit;
    logic [1:0]         lane;
    logic               misaligned;
    logic               err_next;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        rd_word;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_lanes;
    logic [31:0]        rdata_ext;

    assign accept   = (state == DMEM_IDLE) && iReqValid;
    assign commit   = (state == DMEM_WAIT) && (cnt == '0);
    assign word_idx = req_addr[IDX_W+1:2];
    assign rd_word  = mem[word_idx];
    assign err_next = (req_size == MEM_RSVD) || misaligned;

    assign oReqReady = (state == DMEM_IDLE);
    assign oRspValid = (state == DMEM_RESP);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= DMEM_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept)
                cnt <= CNT_W'(LATENCY - 1);
            else if ((state == DMEM_WAIT) && (cnt != '0))
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DMEM_IDLE: if (iReqValid) state_next = DMEM_WAIT;
            DMEM_WAIT: if (cnt == '0) state_next = DMEM_RESP;
            DMEM_RESP: if (iRspReady) state_next = DMEM_IDLE;
            default:   state_next = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (accept) begin
            req_write    <= iReqWrite;
            req_size     <= mem_size_e'(iReqSize);
            req_unsigned <= iReqUnsigned;
            req_addr     <= iReqAddr[IDX_W+1:0];
            req_wdata    <= iReqWData;
        end
    end

    always_comb begin
        lane       = req_addr[1:0];
        misaligned = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        case (req_size)
            MEM_HALF: misaligned = req_addr[0];
            MEM_WORD: misaligned = |req_addr[1:0];
            default:  ;
        endcase
`else
        case (req_size)
            MEM_HALF: lane[0] = 1'b0;
            MEM_WORD: lane    = 2'b00;
            default:  ;
        endcase
`endif
    end

    dmem_lane_align u_lane_align (
        .size        (req_size),
        .lane        (lane),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rdata       (rd_word),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

    // RAM contents survive reset; only the commit edge of a legal store writes.
    always_ff @(posedge iClk) begin
        if (commit && req_write && !err_next) begin
            for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
                if (byte_en[i])
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oRspRData <= '0;
            oRspErr   <= 1'b0;
        end else if (commit) begin
            oRspErr   <= err_next;
            oRspRData <= (err_next || req_write) ? 32'd0 : rdata_ext;
        end
    end

    generate
        if (ADDR_W > IDX_W + 2) begin : g_addr_hi_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^iReqAddr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : directed + randomized bench against a byte-array model
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int ADDR_W  = 32;
    localparam int BUDGET  = 50;

    logic              iClk = 1'b0;
    logic              iRstN;
    logic              iReqValid;
    logic              oReqReady;
    logic              iReqWrite;
    logic [1:0]        iReqSize;
    logic              iReqUnsigned;
    logic [ADDR_W-1:0] iReqAddr;
    logic [31:0]       iReqWData;
    logic              oRspValid;
    logic              iRspReady;
    logic [31:0]       oRspRData;
    logic              oRspErr;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [7:0] ref_mem [DEPTH*4];

    always #5 iClk = ~iClk;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W)
    ) dut (
        .iClk         (iClk),
        .iRstN        (iRstN),
        .iReqValid    (iReqValid),
        .oReqReady    (oReqReady),
        .iReqWrite    (iReqWrite),
        .iReqSize     (iReqSize),
        .iReqUnsigned (iReqUnsigned),
        .iReqAddr     (iReqAddr),
        .iReqWData    (iReqWData),
        .oRspValid    (oRspValid),
        .iRspReady    (iRspReady),
        .oRspRData    (oRspRData),
        .oRspErr      (oRspErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-addressed memory model: size gives a byte count, extension is arithmetic on the count.
    function automatic void ref_access(input bit wr, input logic [1:0] sz, input bit uns,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] data, output bit err);
        longint a, v;
        int n, off;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a    = longint'(addr);
        err  = (sz == 2'd3);
        data = 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!err && (a % n) != 0) err = 1'b1;
`endif
        if (err) return;
        off = int'((a - (a % n)) % (DEPTH * 4));
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[off + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[off + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((longint'(1) << (8 * n)) - 1);
            data = v[31:0];
        end
    endfunction

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic do_req(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          output logic [31:0] got);
        logic [31:0] ed;
        bit          ee;
        int          w;
        ref_access(wr, sz, uns, addr, wd, ed, ee);
        iReqValid    = 1'b1;
        iReqWrite    = wr;
        iReqSize     = sz;
        iReqUnsigned = uns;
        iReqAddr     = addr;
        iReqWData    = wd;
        iRspReady    = (hold == 0);
        w = 0;
        while (!oReqReady && w < BUDGET) begin
            @(negedge iClk);
            w++;
        end
        chk({tag, "/req_ready"}, 32'(oReqReady), 32'd1);
        @(posedge iClk);
        @(negedge iClk);
        iReqValid = 1'b0;
        iReqWData = $urandom;
        repeat (LATENCY) begin
            chk({tag, "/rsp_early"}, 32'(oRspValid), 32'd0);
            chk({tag, "/busy"}, 32'(oReqReady), 32'd0);
            @(negedge iClk);
        end
        w = 0;
        while (!oRspValid && w < BUDGET) begin
            @(negedge iClk);
            w++;
        end
        chk({tag, "/rsp_valid_on_time"}, 32'(w), 32'd0);
        chk({tag, "/rdata"}, oRspRData, ed);
        chk({tag, "/err"}, 32'(oRspErr), 32'(ee));
        got = oRspRData;
        for (int i = 0; i < hold; i++) begin
            @(negedge iClk);
            chk({tag, "/hold_valid"}, 32'(oRspValid), 32'd1);
            chk({tag, "/hold_rdata"}, oRspRData, ed);
            chk({tag, "/hold_busy"}, 32'(oReqReady), 32'd0);
        end
        iRspReady = 1'b1;
        @(negedge iClk);
        chk({tag, "/rsp_done"}, 32'(oRspValid), 32'd0);
        chk({tag, "/idle_ready"}, 32'(oReqReady), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        iRstN        = 1'b0;
        iReqValid    = 1'b0;
        iReqWrite    = 1'b0;
        iReqSize     = 2'd0;
        iReqUnsigned = 1'b0;
        iReqAddr     = '0;
        iReqWData    = '0;
        iRspReady    = 1'b1;
        #2;
        chk("reset/req_ready", 32'(oReqReady), 32'd1);
        chk("reset/rsp_valid", 32'(oRspValid), 32'd0);
        chk("reset/rdata", oRspRData, 32'd0);
        chk("reset/err", 32'(oRspErr), 32'd0);
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        @(negedge iClk);

        // Word round trip
        do_req("st_word", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
        do_req("ld_word", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
        chk("ld_word/const", got, 32'hDEADBEEF);

        // Byte stores and extension
        do_req("preset20", 1'b1, 2'd2, 1'b0, 32'h20, 32'hFFFFFFFF, 0, got);
        do_req("st_b21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h00000080, 0, got);
        do_req("st_b22", 1'b1, 2'd0, 1'b0, 32'h22, 32'hFFFFFF7F, 0, got);
        do_req("ld_sb21", 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 0, got);
        chk("ld_sb21/const", got, 32'hFFFFFF80);
        do_req("ld_ub21", 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, got);
        chk("ld_ub21/const", got, 32'h00000080);
        do_req("ld_w20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, got);
        chk("ld_w20/const", got, 32'hFF7F80FF);

        // Back-pressure
        do_req("st_bp", 1'b1, 2'd2, 1'b0, 32'h30, 32'h12345678, 0, got);
        do_req("ld_bp", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 5, got);
        chk("ld_bp/const", got, 32'h12345678);

        // Wrap and illegal size
        do_req("st_wrap", 1'b1, 2'd2, 1'b0, 32'h1000, 32'hA5A5A5A5, 0, got);
        do_req("ld_wrap", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, got);
        chk("ld_wrap/const", got, 32'hA5A5A5A5);
        do_req("st_rsvd", 1'b1, 2'd3, 1'b0, 32'h10, 32'h0BADF00D, 0, got);
        do_req("ld_rsvd", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, got);
        do_req("ld_after_rsvd", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
        chk("ld_after_rsvd/const", got, 32'hDEADBEEF);

        // Misaligned half load at 0x3
        do_req("ld_mis_h3", 1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("ld_mis_h3/const", got, 32'h00000000);
`else
        chk("ld_mis_h3/const", got, 32'hFFFFA5A5);
`endif

        // Reset during WAIT discards the pending store
        do_req("st_prior40", 1'b1, 2'd2, 1'b0, 32'h40, 32'h22222222, 0, got);
        do_req("ld_prior40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, got);
        iReqValid = 1'b1;
        iReqWrite = 1'b1;
        iReqSize  = 2'd2;
        iReqAddr  = 32'h40;
        iReqWData = 32'h11111111;
        @(posedge iClk);
        @(negedge iClk);
        iReqValid = 1'b0;
        iRstN     = 1'b0;
        #1;
        chk("rst_mid/req_ready", 32'(oReqReady), 32'd1);
        chk("rst_mid/rsp_valid", 32'(oRspValid), 32'd0);
        chk("rst_mid/rdata", oRspRData, 32'd0);
        chk("rst_mid/err", 32'(oRspErr), 32'd0);
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        @(negedge iClk);
        do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, got);
        chk("ld_after_rst/const", got, 32'h22222222);

        // Randomized traffic over a prefilled window, with aliased upper address bits
        for (int i = 0; i < 16; i++)
            do_req("rnd_fill", 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), $urandom, 0, got);
        for (int i = 0; i < 40; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            a[31:12] = 20'($urandom);
            do_req("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)), got);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
